// File: rtl/z80_int_vector_ctrl_if.sv
// Bus bundle between the Z80 core/glue logic and the vectored interrupt
// controller: device requests, CPU control pins, register write strobes,
// INT line, IM2 vector byte, data-in mux select and status byte.
interface z80_int_vector_ctrl_if;
    logic [7:0] irqIn;
    logic       z80M1_n;
    logic       z80Iorq_n;
    logic [7:0] dataIn;
    logic       intMaskWr_cs;
    logic       intBaseWr_cs;
    logic       intEoiWr_cs;
    logic       z80Int_n;
    logic [7:0] intsToCpu;
    logic       intVectToCPU_cs;
    logic [7:0] intStatus;

    // CPU / system side: drives requests, pins and strobes
    modport master (
        output irqIn, z80M1_n, z80Iorq_n, dataIn,
               intMaskWr_cs, intBaseWr_cs, intEoiWr_cs,
        input  z80Int_n, intsToCpu, intVectToCPU_cs, intStatus
    );

    // Controller side
    modport slave (
        input  irqIn, z80M1_n, z80Iorq_n, dataIn,
               intMaskWr_cs, intBaseWr_cs, intEoiWr_cs,
        output z80Int_n, intsToCpu, intVectToCPU_cs, intStatus
    );
endinterface

// File: rtl/z80_int_vector_ctrl.sv
// Z80 IM2 vectored interrupt controller (pll0_250MHz domain).
// Eight prioritised requests (bit 0 highest), INT generation, vector byte
// and data-in mux select during INTA, EOI-terminated service.
// Optional macro INTC_EDGE_DETECT_EN: pending latches on request rising
// edges and is cleared on acknowledge; otherwise pending follows the
// synchronised request level.
module z80_int_vector_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic                 pll0_250MHz,
    input  logic                 resetn,
    z80_int_vector_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, ACK, SVC} state_t;

    state_t state, nextState;

    logic [NUM_SRC-1:0] irqSync_p0, irqSync_p1;
    logic [1:0]         m1Sync, iorqSync;
    logic               intaPrev;
    logic               maskWrPrev, baseWrPrev, eoiWrPrev;
    logic [NUM_SRC-1:0] mask, pending, req;
    logic [3:0]         base;
    logic [2:0]         svcIdx;
    logic [7:0]         vecLatch;
    logic               spurious, spurAck, z80IntReg;

    logic       inta, intaRise, maskWr, baseWr, eoiWr;
    logic       ackTake, spurTake, sel;
    logic [2:0] winIdx;

    function automatic logic [2:0] lowestIdx(input logic [NUM_SRC-1:0] v);
        lowestIdx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowestIdx = i[2:0];
        end
    endfunction

    assign inta     = ~m1Sync[1] & ~iorqSync[1];
    assign intaRise = inta & ~intaPrev;
    assign maskWr   = bus.intMaskWr_cs & ~maskWrPrev;
    assign baseWr   = bus.intBaseWr_cs & ~baseWrPrev;
    assign eoiWr    = bus.intEoiWr_cs  & ~eoiWrPrev;
    assign req      = pending & ~mask;
    assign winIdx   = lowestIdx(req);
    assign ackTake  = (state == REQ) && (req != '0) && intaRise;
    assign spurTake = intaRise && ((state == IDLE) || (state == SVC));

    // Two-flop synchronisers for requests and CPU pins, plus edge history
    always_ff @(posedge pll0_250MHz or negedge resetn) begin
        if (!resetn) begin
            irqSync_p0 <= '0;
            irqSync_p1 <= '0;
            m1Sync     <= 2'b11;
            iorqSync   <= 2'b11;
            intaPrev   <= 1'b0;
            maskWrPrev <= 1'b0;
            baseWrPrev <= 1'b0;
            eoiWrPrev  <= 1'b0;
        end else begin
            irqSync_p0 <= bus.irqIn;
            irqSync_p1 <= irqSync_p0;
            m1Sync     <= {m1Sync[0], bus.z80M1_n};
            iorqSync   <= {iorqSync[0], bus.z80Iorq_n};
            intaPrev   <= inta;
            maskWrPrev <= bus.intMaskWr_cs;
            baseWrPrev <= bus.intBaseWr_cs;
            eoiWrPrev  <= bus.intEoiWr_cs;
        end
    end

`ifdef INTC_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] irqPrev_p2, irqRise, ackClr;
    assign irqRise = irqSync_p1 & ~irqPrev_p2;
    assign ackClr  = ackTake ? (NUM_SRC'(1) << winIdx) : '0;

    // Edge-latched pending; a new edge wins over the acknowledge clear
    always_ff @(posedge pll0_250MHz or negedge resetn) begin
        if (!resetn) begin
            irqPrev_p2 <= '0;
            pending    <= '0;
        end else begin
            irqPrev_p2 <= irqSync_p1;
            pending    <= (pending & ~ackClr) | irqRise;
        end
    end
`else
    // Level mode: pending mirrors the synchronised request lines
    always_ff @(posedge pll0_250MHz or negedge resetn) begin
        if (!resetn) pending <= '0;
        else         pending <= irqSync_p1;
    end
`endif

    // CPU-writable mask and vector base, one update per strobe
    always_ff @(posedge pll0_250MHz or negedge resetn) begin
        if (!resetn) begin
            mask <= '1;
            base <= 4'h0;
        end else begin
            if (maskWr) mask <= bus.dataIn[NUM_SRC-1:0];
            if (baseWr) base <= bus.dataIn[7:4];
        end
    end

    // FSM state, latched vector/index, spurious tracking and INT line
    always_ff @(posedge pll0_250MHz or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            svcIdx    <= 3'd0;
            vecLatch  <= 8'h00;
            spurAck   <= 1'b0;
            spurious  <= 1'b0;
            z80IntReg <= 1'b1;
        end else begin
            state <= nextState;
            if (ackTake) begin
                svcIdx   <= winIdx;
                vecLatch <= {base, winIdx, 1'b0};
            end else if (spurTake) begin
                vecLatch <= {base, 3'b111, 1'b0};
            end
            if (spurTake)   spurAck <= 1'b1;
            else if (!inta) spurAck <= 1'b0;
            if (spurTake)   spurious <= 1'b1;
            else if (eoiWr) spurious <= 1'b0;
            // INT stays low only while we remain in REQ, so it releases on
            // the same edge that leaves REQ (acknowledge or mask race)
            z80IntReg <= ~((state == REQ) && (nextState == REQ));
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (req != '0) nextState = REQ;
            REQ: begin
                if (req == '0)    nextState = IDLE;
                else if (intaRise) nextState = ACK;
            end
            ACK:  if (!inta) nextState = SVC;
            SVC:  if (eoiWr) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign sel                 = (state == ACK) | spurAck;
    assign bus.z80Int_n        = z80IntReg;
    assign bus.intVectToCPU_cs = sel;
    assign bus.intsToCpu       = sel ? vecLatch : 8'h00;
    assign bus.intStatus       = {(state == SVC), (state == REQ), spurious, 2'b00,
                                  ((state == ACK) || (state == SVC)) ? svcIdx : 3'b000};
endmodule

// File: doc/z80_int_vector_ctrl.md
# z80_int_vector_ctrl

Vectored interrupt controller for the Z80 soft-core system, running in the `pll0_250MHz` domain. It latches up to eight device interrupt requests, prioritises them, and drives the Z80 `INT` line. During the interrupt-acknowledge cycle it supplies the IM2 vector byte and the select that the CPU data-in multiplexer uses to route that byte onto the CPU bus. Each service period ends with an end-of-interrupt (EOI) write from the CPU.

## Interface
Parameters:
- `NUM_SRC`, 8: number of request inputs. Fixed at 8; the vector encodes 3 index bits.

Ports:
- `pll0_250MHz` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `irqIn` in 8: device requests, asynchronous to the clock; bit 0 has highest priority.
- `z80M1_n` in 1: Z80 M1, asynchronous.
- `z80Iorq_n` in 1: Z80 IORQ, asynchronous.
- `dataIn` in 8: CPU write data.
- `intMaskWr_cs` in 1: write strobe for the mask register. A 1 bit masks that source.
- `intBaseWr_cs` in 1: write strobe for the vector base; `dataIn[7:4]` is taken.
- `intEoiWr_cs` in 1: write strobe for EOI; data is ignored.
- `z80Int_n` out 1: interrupt request to the CPU, registered.
- `intsToCpu` out 8: vector byte.
- `intVectToCPU_cs` out 1: vector-valid select to the data-in multiplexer.
- `intStatus` out 8: status byte, `{inSvc, reqActive, spurious, 2'b0, svcIdx[2:0]}`.

## Operation
- **Synchronisation.** `irqIn`, `z80M1_n` and `z80Iorq_n` each pass through a 2-flop synchroniser.
  - `inta` = synchronised M1 low AND synchronised IORQ low.
  - `intaRise` is the first cycle in which `inta` is true.
- **Write strobes.** Each `*_cs` is rising-edge detected, so a strobe held high for many cycles acts exactly once.
- **Pending register** (8 bits):
  - Set by the source event (see Configuration).
  - Cleared for index `i` when `i` is acknowledged.
  - If a set and a clear of the same bit occur in the same cycle, set wins.
  - Masked sources still latch pending; they do not request.
- **Winner.** `req = pending & ~mask`. The winner is the lowest set index of `req`.
- **Vector.** `intsToCpu = {base[3:0], idx[2:0], 1'b0}`.
- **FSM states:** IDLE, REQ, ACK, SVC.
  - **IDLE:** if `req != 0` → REQ. If `intaRise` occurs here, it is spurious; see the boundary cases.
  - **REQ:** `z80Int_n = 0`.
    - If `req == 0` (source masked before acknowledge) → IDLE, and `z80Int_n` is released.
    - On `intaRise`: latch winner into `svcIdx`, clear its pending bit, → ACK.
  - **ACK:** `intVectToCPU_cs = 1`, `intsToCpu` is driven from `svcIdx`, `z80Int_n = 1`. When `inta` deasserts → SVC, with the select dropped.
  - **SVC:** `inSvc = 1`. There is no nesting; new requests wait pending. On EOI → IDLE.
- **EOI outside SVC.** No state change. It still clears `spurious`.
- **Boundary cases:**
  - **Spurious acknowledge** (`intaRise` in IDLE or SVC): the block asserts `intVectToCPU_cs` for the duration of `inta`. It drives the vector `{base, 3'b111, 1'b0}`. It sets `spurious`. Neither the state nor the pending register changes.
  - **Mask or base write during ACK:** takes effect for the next request. The latched vector does not change.
- **Status bits:** `reqActive` = (state == REQ). `spurious` is cleared by EOI.
- **Reset values:**
  - Registers and state: mask = 8'hFF, base = 0, pending = 0, state = IDLE.
  - Outputs: `z80Int_n` = 1, `intsToCpu` = 8'h00, `intVectToCPU_cs` = 0, `intStatus` = 8'h00.
- **Reset mid-operation:** asynchronously returns everything to reset values. Any in-service or pending request is lost.

## Timing
- `irqIn` rising edge → pending set: 3 clocks (2 synchroniser + 1 detect).
- Pending, unmasked, in IDLE → `z80Int_n` low: 2 clocks (IDLE→REQ, registered output).
- `inta` pin assertion → `intVectToCPU_cs` high and vector valid: 3 clocks (12 ns). This is well inside the Z80 INTA window.
- `inta` pin release → select low: 3 clocks.
- Write strobe rising edge → register updated: 1 clock. The new mask affects `req` on the next cycle.
- EOI → IDLE → next `z80Int_n` low: 2 clocks if a request is waiting.

## Configuration
- Macro: `INTC_EDGE_DETECT_EN`.
- **Defined:** pending bit `i` is set on a synchronised rising edge of `irqIn[i]`. It is held until acknowledged.
- **Undefined (level mode):**
  - `pending` equals the synchronised `irqIn` level each cycle.
  - The acknowledge clear has no effect; the source must drop its request before EOI.
  - A request that drops in REQ returns the FSM to IDLE.

## Test plan
- **Reset:** hold `resetn` low → `z80Int_n` = 1, `intStatus` = 8'h00, `intVectToCPU_cs` = 0. After release, mask reads back internally as 8'hFF; `irqIn` = 8'h01 produces no `z80Int_n`.
- **Basic acknowledge:** write base = 8'hA0, mask = 8'h00, pulse `irqIn[3]`.
  - `z80Int_n` goes low 5 clocks after the pulse.
  - Drive M1 and IORQ low → `intVectToCPU_cs` = 1 and `intsToCpu` = 8'hA6.
  - `intStatus` = 8'h83 after acknowledge completes.
  - EOI → `intStatus` = 8'h00.
- **Priority:** pulse `irqIn[5]` and `irqIn[2]` in the same cycle.
  - First vector = 8'hA4; `irqIn[5]` stays pending.
  - After EOI, second vector = 8'hAA.
- **Mask race:** in REQ for `irqIn[1]`, write mask = 8'h02 → `z80Int_n` returns to 1 and the FSM goes to IDLE. Write mask = 8'h00 → request reasserts.
- **Spurious acknowledge:** INTA in IDLE with base = 8'hA0 → vector 8'hAE, `intStatus` = 8'h20. EOI → `intStatus` = 8'h00.
- **Reset mid-service:** assert `resetn` low during ACK → select drops immediately and all outputs return to reset values.
